hazard_ctrl_unit: RTL and testbench

//  Pipeline sequencer for the IF/ID and ID/EX stage registers of the PA-RISC PPU.

---
 rtl/ppu_pkg.sv | 25 ++
 rtl/hazard_fwd_sel.sv | 33 +++
 rtl/hazard_ctrl_unit.sv | 185 ++++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared definitions for the PA-RISC PPU pipeline control blocks:
// hazard FSM state encodings, forwarding-select codes and the hardwired-zero register.
package ppu_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLdStall = 2'd1,
    StBrFlush = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  localparam logic [4:0] GR0 = 5'd0;

  // A source register depends on a producer only if it is really read, is not GR0,
  // and the producer actually writes the register file.
  function automatic logic reg_match(input logic [4:0] rs, input logic rs_use,
                                     input logic [4:0] rd, input logic rd_le);
    return (rs != GR0) && rs_use && (rs == rd) && rd_le;
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding select: compares one ID source register against the
// EX/MEM/WB destinations and picks the youngest valid producer (EX > MEM > WB > RF).
// ex_hit reports a raw EX match so the parent can detect load-use hazards.
module hazard_fwd_sel
  import ppu_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       rs_use,
  input  logic [4:0] ex_rd,
  input  logic       ex_rf_le,
  input  logic       ex_l,
  input  logic [4:0] mem_rd,
  input  logic       mem_rf_le,
  input  logic [4:0] wb_rd,
  input  logic       wb_rf_le,
  output logic [1:0] sel,
  output logic       ex_hit
);

  // Priority compare; a load in EX has no data yet, so it never forwards.
  always_comb begin
    sel    = FWD_RF;
    ex_hit = reg_match(rs, rs_use, ex_rd, ex_rf_le);
    if (ex_hit && !ex_l) begin
      sel = FWD_EX;
    end else if (reg_match(rs, rs_use, mem_rd, mem_rf_le)) begin
      sel = FWD_MEM;
    end else if (reg_match(rs, rs_use, wb_rd, wb_rf_le)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline sequencer for the IF/ID and ID/EX stage registers of the PPU.
// Detects load-use hazards and taken-branch squashes, drives PC/IF-ID load enables,
// the IF/ID flush and the ID/EX bubble, and produces operand forwarding selects.
// Optional feature macro: HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_ctrl_unit
  import ppu_pkg::*;
#(
  parameter int unsigned LD_STALL_CYC = 1,
  parameter int unsigned BR_FLUSH_CYC = 1
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [4:0]       id_ra,
  input  logic             id_ra_use,
  input  logic [4:0]       id_rb,
  input  logic             id_rb_use,
  input  logic [4:0]       ex_rd,
  input  logic             ex_rf_le,
  input  logic             ex_l,
  input  logic [4:0]       mem_rd,
  input  logic             mem_rf_le,
  input  logic [4:0]       wb_rd,
  input  logic             wb_rf_le,
  input  logic             ex_br_taken,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic             pc_le,
  output logic             ifid_le,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel
);

  localparam logic [2:0] LdLoad = 3'(LD_STALL_CYC - 1);
  localparam logic [2:0] BrLoad = 3'(BR_FLUSH_CYC - 1);

  hz_state_e  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       a_ex_hit, b_ex_hit;
  logic [1:0] a_sel_raw, b_sel_raw;
  logic       lu_haz;
  logic       take_br;
  logic       stall_evt;
  logic       flush_evt;

  hazard_fwd_sel u_fwd_a (
    .rs        (id_ra),
    .rs_use    (id_ra_use),
    .ex_rd     (ex_rd),
    .ex_rf_le  (ex_rf_le),
    .ex_l      (ex_l),
    .mem_rd    (mem_rd),
    .mem_rf_le (mem_rf_le),
    .wb_rd     (wb_rd),
    .wb_rf_le  (wb_rf_le),
    .sel       (a_sel_raw),
    .ex_hit    (a_ex_hit)
  );

  hazard_fwd_sel u_fwd_b (
    .rs        (id_rb),
    .rs_use    (id_rb_use),
    .ex_rd     (ex_rd),
    .ex_rf_le  (ex_rf_le),
    .ex_l      (ex_l),
    .mem_rd    (mem_rd),
    .mem_rf_le (mem_rf_le),
    .wb_rd     (wb_rd),
    .wb_rf_le  (wb_rf_le),
    .sel       (b_sel_raw),
    .ex_hit    (b_ex_hit)
  );

  assign lu_haz = ex_l && (a_ex_hit || b_ex_hit);
  // Branch in EX wins everywhere except while already flushing (that branch is squashed).
  assign take_br = ex_br_taken && (state_q != StBrFlush);

  // Forwarding is forced to the RF path while reset is held.
  assign fwd_a_sel = Reset ? FWD_RF : a_sel_raw;
  assign fwd_b_sel = Reset ? FWD_RF : b_sel_raw;

  // State and countdown register.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StRun;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and enable decode; reset overrides outputs combinationally.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_le       = 1'b1;
    ifid_le     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stall_evt   = 1'b0;
    flush_evt   = 1'b0;

    if (take_br) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      flush_evt   = 1'b1;
      if (BR_FLUSH_CYC > 1) begin
        state_d = StBrFlush;
        cnt_d   = BrLoad;
      end else begin
        state_d = StRun;
        cnt_d   = 3'd0;
      end
    end else begin
      unique case (state_q)
        StRun: begin
          if (lu_haz) begin
            pc_le       = 1'b0;
            ifid_le     = 1'b0;
            idex_bubble = 1'b1;
            stall_evt   = 1'b1;
            if (LD_STALL_CYC > 1) begin
              state_d = StLdStall;
              cnt_d   = LdLoad;
            end
          end
        end
        StLdStall: begin
          pc_le       = 1'b0;
          ifid_le     = 1'b0;
          idex_bubble = 1'b1;
          stall_evt   = 1'b1;
          cnt_d       = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = StRun;
        end
        StBrFlush: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          flush_evt   = 1'b1;
          cnt_d       = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = StRun;
        end
        default: begin
          state_d = StRun;
          cnt_d   = 3'd0;
        end
      endcase
    end

    if (Reset) begin
      pc_le       = 1'b0;
      ifid_le     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      stall_evt   = 1'b0;
      flush_evt   = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating performance counters.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  // Event strobes only feed the optional counters.
  logic unused_evt;
  assign unused_evt = stall_evt ^ flush_evt;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: a default instance (1-cycle stall/flush) and a
// second instance with LD_STALL_CYC=3, BR_FLUSH_CYC=2 share the same stimulus.
// Define HAZARD_PERF_CNT_EN to also check the performance counters.
module tb_hazard_ctrl_unit;

  logic       clk;
  logic       Reset;
  logic [4:0] id_ra, id_rb, ex_rd, mem_rd, wb_rd;
  logic       id_ra_use, id_rb_use, ex_rf_le, ex_l, mem_rf_le, wb_rf_le, ex_br_taken;

  logic       pc_le, ifid_le, ifid_flush, idex_bubble;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       pc_le3, ifid_le3, ifid_flush3, idex_bubble3;
  logic [1:0] fwd_a_sel3, fwd_b_sel3;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt, stall_cnt3, flush_cnt3;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  hazard_ctrl_unit u_dut (
    .clk         (clk),
    .Reset       (Reset),
    .id_ra       (id_ra),
    .id_ra_use   (id_ra_use),
    .id_rb       (id_rb),
    .id_rb_use   (id_rb_use),
    .ex_rd       (ex_rd),
    .ex_rf_le    (ex_rf_le),
    .ex_l        (ex_l),
    .mem_rd      (mem_rd),
    .mem_rf_le   (mem_rf_le),
    .wb_rd       (wb_rd),
    .wb_rf_le    (wb_rf_le),
    .ex_br_taken (ex_br_taken),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
`endif
    .pc_le       (pc_le),
    .ifid_le     (ifid_le),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel)
  );

  hazard_ctrl_unit #(
    .LD_STALL_CYC (3),
    .BR_FLUSH_CYC (2)
  ) u_dut3 (
    .clk         (clk),
    .Reset       (Reset),
    .id_ra       (id_ra),
    .id_ra_use   (id_ra_use),
    .id_rb       (id_rb),
    .id_rb_use   (id_rb_use),
    .ex_rd       (ex_rd),
    .ex_rf_le    (ex_rf_le),
    .ex_l        (ex_l),
    .mem_rd      (mem_rd),
    .mem_rf_le   (mem_rf_le),
    .wb_rd       (wb_rd),
    .wb_rf_le    (wb_rf_le),
    .ex_br_taken (ex_br_taken),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt   (stall_cnt3),
    .flush_cnt   (flush_cnt3),
`endif
    .pc_le       (pc_le3),
    .ifid_le     (ifid_le3),
    .ifid_flush  (ifid_flush3),
    .idex_bubble (idex_bubble3),
    .fwd_a_sel   (fwd_a_sel3),
    .fwd_b_sel   (fwd_b_sel3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    id_ra = 5'd0; id_ra_use = 1'b0; id_rb = 5'd0; id_rb_use = 1'b0;
    ex_rd = 5'd0; ex_rf_le = 1'b0; ex_l = 1'b0;
    mem_rd = 5'd0; mem_rf_le = 1'b0; wb_rd = 5'd0; wb_rf_le = 1'b0;
    ex_br_taken = 1'b0;
  endtask

  // Load in EX writing r5, ID reads r5 on operand A.
  task automatic set_lu();
    clr();
    ex_l = 1'b1; ex_rd = 5'd5; ex_rf_le = 1'b1;
    id_ra = 5'd5; id_ra_use = 1'b1;
  endtask

  initial begin
    Reset = 1'b1;
    clr();
    #1;
    // Reset values
    chk("rst_pc_le", pc_le, 1'b0);
    chk("rst_ifid_le", ifid_le, 1'b0);
    chk("rst_ifid_flush", ifid_flush, 1'b1);
    chk("rst_idex_bubble", idex_bubble, 1'b1);
    chk("rst_fwd_a", fwd_a_sel, 2'd0);
    chk("rst_fwd_b", fwd_b_sel, 2'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    chk("rst_flush_cnt", flush_cnt, 16'd0);
`endif

    @(negedge clk); Reset = 1'b0; #1;
    chk("run_pc_le", pc_le, 1'b1);
    chk("run_ifid_le", ifid_le, 1'b1);
    chk("run_ifid_flush", ifid_flush, 1'b0);
    chk("run_idex_bubble", idex_bubble, 1'b0);

    // Load-use on r5: one bubble cycle, then the load result comes from MEM
    @(negedge clk); set_lu(); #1;
    chk("lu_pc_le", pc_le, 1'b0);
    chk("lu_ifid_le", ifid_le, 1'b0);
    chk("lu_idex_bubble", idex_bubble, 1'b1);
    chk("lu_fwd_a_no_ex", fwd_a_sel, 2'd0);
    @(negedge clk);
    clr(); id_ra = 5'd5; id_ra_use = 1'b1; mem_rd = 5'd5; mem_rf_le = 1'b1; #1;
    chk("lu_after_pc_le", pc_le, 1'b1);
    chk("lu_after_bubble", idex_bubble, 1'b0);
    chk("lu_after_fwd_a", fwd_a_sel, 2'd2);
`ifdef HAZARD_PERF_CNT_EN
    chk("lu_stall_cnt", stall_cnt, 16'd1);
`endif

    // GR0 never hazards nor forwards
    @(negedge clk); clr();
    ex_l = 1'b1; ex_rd = 5'd0; ex_rf_le = 1'b1; id_ra = 5'd0; id_ra_use = 1'b1;
    mem_rd = 5'd0; mem_rf_le = 1'b1; #1;
    chk("gr0_pc_le", pc_le, 1'b1);
    chk("gr0_bubble", idex_bubble, 1'b0);
    chk("gr0_fwd_a", fwd_a_sel, 2'd0);

    // Branch taken together with a load-use hazard: branch wins
    @(negedge clk); set_lu(); ex_br_taken = 1'b1; #1;
    chk("br_pc_le", pc_le, 1'b1);
    chk("br_ifid_flush", ifid_flush, 1'b1);
    chk("br_idex_bubble", idex_bubble, 1'b1);
    @(negedge clk); clr(); #1;
    chk("br_after_flush", ifid_flush, 1'b0);
    chk("br_after_bubble", idex_bubble, 1'b0);
    chk("br_after_pc_le", pc_le, 1'b1);
`ifdef HAZARD_PERF_CNT_EN
    chk("br_stall_cnt", stall_cnt, 16'd1);
    chk("br_flush_cnt", flush_cnt, 16'd1);
`endif

    // Forwarding priority on operand B
    @(negedge clk); clr();
    ex_rd = 5'd7; mem_rd = 5'd7; wb_rd = 5'd7;
    ex_rf_le = 1'b1; mem_rf_le = 1'b1; wb_rf_le = 1'b1;
    id_rb = 5'd7; id_rb_use = 1'b1; #1;
    chk("fwd_b_ex", fwd_b_sel, 2'd1);
    chk("fwd_a_unused", fwd_a_sel, 2'd0);
    chk("fwd_no_stall", idex_bubble, 1'b0);
    ex_rf_le = 1'b0; #1;
    chk("fwd_b_mem", fwd_b_sel, 2'd2);
    mem_rf_le = 1'b0; #1;
    chk("fwd_b_wb", fwd_b_sel, 2'd3);
    wb_rf_le = 1'b0; #1;
    chk("fwd_b_rf", fwd_b_sel, 2'd0);
    ex_rf_le = 1'b1; ex_l = 1'b1; mem_rf_le = 1'b1; id_rb_use = 1'b0; #1;
    chk("fwd_b_nouse", fwd_b_sel, 2'd0);
    id_rb_use = 1'b1; #1;
    chk("fwd_b_load_skips_ex", fwd_b_sel, 2'd2);

    // Reset asserted mid LD_STALL on the 3-cycle instance
    @(negedge clk); set_lu(); #1;
    chk("r3_first_bubble", idex_bubble3, 1'b1);
    @(negedge clk); clr(); #1;
    chk("r3_stall_pc_le", pc_le3, 1'b0);
    chk("r3_stall_bubble", idex_bubble3, 1'b1);
    set_lu(); #2; Reset = 1'b1; #1;
    chk("r3_async_pc_le", pc_le3, 1'b0);
    chk("r3_async_ifid_le", ifid_le3, 1'b0);
    chk("r3_async_flush", ifid_flush3, 1'b1);
    chk("r3_async_bubble", idex_bubble3, 1'b1);
    chk("r3_async_fwd_a", fwd_a_sel3, 2'd0);
    @(negedge clk); clr(); Reset = 1'b0; #1;
    chk("r3_rel_pc_le", pc_le3, 1'b1);
    chk("r3_rel_bubble", idex_bubble3, 1'b0);
    chk("r3_rel_flush", ifid_flush3, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    chk("r3_rel_stall_cnt", stall_cnt3, 16'd0);
`endif

    // LD_STALL_CYC=3: exactly three bubble cycles
    @(negedge clk); set_lu(); #1;
    chk("s3_bubble1", idex_bubble3, 1'b1);
    @(negedge clk); clr(); #1;
    chk("s3_bubble2", idex_bubble3, 1'b1);
    chk("s3_pc_le2", pc_le3, 1'b0);
    @(negedge clk); #1;
    chk("s3_bubble3", idex_bubble3, 1'b1);
    chk("s3_ifid_le3", ifid_le3, 1'b0);
    @(negedge clk); #1;
    chk("s3_run_bubble", idex_bubble3, 1'b0);
    chk("s3_run_pc_le", pc_le3, 1'b1);
`ifdef HAZARD_PERF_CNT_EN
    chk("s3_stall_cnt", stall_cnt3, 16'd3);
    chk("s3_stall_cnt_dflt", stall_cnt, 16'd1);
`endif

    // Branch during LD_STALL wins; 2-cycle flush, second branch ignored
    @(negedge clk); set_lu(); #1;
    chk("lb_bubble", idex_bubble3, 1'b1);
    @(negedge clk); clr(); ex_br_taken = 1'b1; #1;
    chk("lb_br_pc_le", pc_le3, 1'b1);
    chk("lb_br_flush", ifid_flush3, 1'b1);
    chk("lb_br_bubble", idex_bubble3, 1'b1);
    @(negedge clk); #1;
    chk("lb_fl_pc_le", pc_le3, 1'b1);
    chk("lb_fl_flush", ifid_flush3, 1'b1);
    @(negedge clk); clr(); #1;
    chk("lb_run_flush", ifid_flush3, 1'b0);
    chk("lb_run_bubble", idex_bubble3, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    chk("lb_stall_cnt", stall_cnt3, 16'd4);
    chk("lb_flush_cnt", flush_cnt3, 16'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
